// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS control FSM with memory handshake, timeout, interrupts and exceptions
module mc_ctrl_fsm #(
    parameter int NIRQ        = 6,
    parameter int MEM_TIMEOUT = 255,
    parameter int ECODE_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         cls,
    input  logic               br_take,
    input  logic [1:0]         br_sel,
    input  logic               alu_ovf,
    input  logic               mem_ack,
    input  logic [NIRQ-1:0]    irq,
    input  logic [NIRQ-1:0]    irq_mask,
    input  logic               ie,
    input  logic               exl,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_ifetch,
    output logic               pc_wr,
    output logic [2:0]         npc_sel,
    output logic               ir_wr,
    output logic               gpr_wr,
    output logic               cp0_we,
    output logic               exl_set,
    output logic               exl_clr,
    output logic               epc_wr,
    output logic               epc_sel,
    output logic               cause_wr,
    output logic [ECODE_W-1:0] exc_code,
    output logic [NIRQ-1:0]    irq_pending,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_EXC = 3'd5;

    localparam logic [2:0] C_ALU   = 3'd0;
    localparam logic [2:0] C_LOAD  = 3'd1;
    localparam logic [2:0] C_STORE = 3'd2;
    localparam logic [2:0] C_BR    = 3'd3;
    localparam logic [2:0] C_JAL   = 3'd4;
    localparam logic [2:0] C_MTC0  = 3'd5;
    localparam logic [2:0] C_ERET  = 3'd6;
    localparam logic [2:0] C_ILL   = 3'd7;

    localparam logic [2:0] NPC_SEQ  = 3'd0;
    localparam logic [2:0] NPC_JUMP = 3'd2;
    localparam logic [2:0] NPC_VEC  = 3'd4;
    localparam logic [2:0] NPC_EPC  = 3'd5;

    localparam logic [ECODE_W-1:0] EC_INT = ECODE_W'(0);
    localparam logic [ECODE_W-1:0] EC_IBE = ECODE_W'(6);
    localparam logic [ECODE_W-1:0] EC_DBE = ECODE_W'(7);
    localparam logic [ECODE_W-1:0] EC_RI  = ECODE_W'(10);
    localparam logic [ECODE_W-1:0] EC_OV  = ECODE_W'(12);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]         state_q, state_d;
    logic [2:0]         cls_q, cls_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [ECODE_W-1:0] exc_code_q, exc_code_d;
    logic [NIRQ-1:0]    irq_pending_q, irq_pending_d;
    logic               epc_sel_q, epc_sel_d;

    logic [NIRQ-1:0]    irq_masked;
    logic               irq_take;
    logic               mem_busy;
    logic               tmo_expire;
    logic               boundary;

    assign irq_masked = irq & irq_mask;
    assign irq_take   = (|irq_masked) && ie && !exl;
    assign mem_busy   = (state_q == S_IF) || (state_q == S_MEM);
    // Ack on the last permitted cycle still completes the transfer.
    assign tmo_expire = (MEM_TIMEOUT != 0) && mem_busy && !mem_ack && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IF;
            cls_q         <= C_ALU;
            tmo_q         <= '0;
            exc_code_q    <= '0;
            irq_pending_q <= '0;
            epc_sel_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            tmo_q         <= tmo_d;
            exc_code_q    <= exc_code_d;
            irq_pending_q <= irq_pending_d;
            epc_sel_q     <= epc_sel_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        exc_code_d    = exc_code_q;
        irq_pending_d = irq_pending_q;
        epc_sel_d     = epc_sel_q;
        boundary      = 1'b0;

        case (state_q)
            S_IF: begin
                if (mem_ack) begin
                    state_d = S_ID;
                end else if (tmo_expire) begin
                    state_d    = S_EXC;
                    exc_code_d = EC_IBE;
                    epc_sel_d  = 1'b0;
                end
            end
            S_ID: begin
                cls_d = cls;
                if (cls == C_ILL) begin
                    state_d    = S_EXC;
                    exc_code_d = EC_RI;
                    epc_sel_d  = 1'b1;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (cls_q)
                    C_ALU: begin
                        if (alu_ovf) begin
                            state_d    = S_EXC;
                            exc_code_d = EC_OV;
                            epc_sel_d  = 1'b1;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         boundary = 1'b1;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (cls_q == C_LOAD) state_d = S_WB;
                    else                 boundary = 1'b1;
                end else if (tmo_expire) begin
                    state_d    = S_EXC;
                    exc_code_d = EC_DBE;
                    epc_sel_d  = 1'b1;
                end
            end
            S_WB:    boundary = 1'b1;
            S_EXC:   state_d  = S_IF;
            default: state_d  = S_IF;
        endcase

        // Interrupts are only recognised between instructions.
        if (boundary) begin
            if (irq_take) begin
                state_d       = S_EXC;
                exc_code_d    = EC_INT;
                epc_sel_d     = 1'b0;
                irq_pending_d = irq_masked;
            end else begin
                state_d = S_IF;
            end
        end

        if ((state_d != state_q) || mem_ack) begin
            tmo_d = '0;
        end else if (mem_busy) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_ifetch = 1'b0;
        pc_wr      = 1'b0;
        npc_sel    = NPC_SEQ;
        ir_wr      = 1'b0;
        gpr_wr     = 1'b0;
        cp0_we     = 1'b0;
        exl_set    = 1'b0;
        exl_clr    = 1'b0;
        epc_wr     = 1'b0;
        epc_sel    = 1'b0;
        cause_wr   = 1'b0;

        case (state_q)
            S_IF: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ack) begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                end
            end
            S_EX: begin
                case (cls_q)
                    C_BR: begin
                        pc_wr   = br_take;
                        npc_sel = {1'b0, br_sel};
                    end
                    C_JAL: begin
                        pc_wr   = 1'b1;
                        npc_sel = NPC_JUMP;
                        gpr_wr  = 1'b1;
                    end
                    C_MTC0: cp0_we = 1'b1;
                    C_ERET: begin
                        pc_wr   = 1'b1;
                        npc_sel = NPC_EPC;
                        exl_clr = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == C_STORE);
            end
            S_WB: gpr_wr = 1'b1;
            S_EXC: begin
                pc_wr    = 1'b1;
                npc_sel  = NPC_VEC;
                epc_wr   = 1'b1;
                exl_set  = 1'b1;
                cause_wr = 1'b1;
                epc_sel  = epc_sel_q;
            end
            default: ;
        endcase

        // An in-flight request is dropped the moment reset asserts.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_ifetch = 1'b0;
            pc_wr      = 1'b0;
            npc_sel    = NPC_SEQ;
            ir_wr      = 1'b0;
            gpr_wr     = 1'b0;
            cp0_we     = 1'b0;
            exl_set    = 1'b0;
            exl_clr    = 1'b0;
            epc_wr     = 1'b0;
            epc_sel    = 1'b0;
            cause_wr   = 1'b0;
        end
    end

    assign exc_code    = exc_code_q;
    assign irq_pending = irq_pending_q;
    assign state       = state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multi-cycle control FSM for the MIPS core, the successor to the fixed 6-state controller. It takes a pre-decoded instruction class from the decoder, not raw opcode decode. It adds a variable-latency memory handshake (req/ack) with a bus-error timeout, NIRQ maskable interrupt lines, and precise synchronous exceptions (illegal instruction, overflow, bus error). It drives PC/IR/GPR/CP0 write strobes and the next-PC select.

Parameters:
NIRQ, 6, number of interrupt request lines.
MEM_TIMEOUT, 255, cycles without mem_ack before bus error; 0 disables the timeout.
ECODE_W, 5, width of exc_code.

Ports:
clk  in  1  clock
rst  in  1  reset
cls  in  3  instruction class, valid from ID: 0 ALU/MFC0, 1 LOAD, 2 STORE, 3 BRANCH/J/JR, 4 JAL, 5 MTC0, 6 ERET, 7 ILLEGAL
br_take  in  1  branch/jump taken (EX, cls=3)
br_sel  in  2  target kind: 1 branch, 2 jump, 3 jr
alu_ovf  in  1  signed overflow from ALU (EX, cls=0 trapping ops)
mem_ack  in  1  memory/device ack for current request
irq  in  NIRQ  level interrupt requests
irq_mask  in  NIRQ  CP0 SR.IM
ie  in  1  CP0 SR.IE
exl  in  1  CP0 SR.EXL
mem_req  out  1  bus request
mem_we  out  1  write request (STORE)
mem_ifetch  out  1  request is an instruction fetch
pc_wr  out  1  PC write
npc_sel  out  3  0 PC+4, 1 branch, 2 jump, 3 jr, 4 exception vector, 5 EPC
ir_wr  out  1  IR write
gpr_wr  out  1  register file write
cp0_we  out  1  CP0 register write (MTC0)
exl_set  out  1  set SR.EXL
exl_clr  out  1  clear SR.EXL
epc_wr  out  1  EPC write
epc_sel  out  1  0 current PC (next instr), 1 PC-4 (faulting instr)
cause_wr  out  1  Cause write
exc_code  out  ECODE_W  registered exception code
irq_pending  out  NIRQ  registered masked irq snapshot
state  out  3  debug: current state

Behaviour:
- Reset is asynchronous and active-high (rst). Clock is clk.
- On reset: state=IF, timeout counter=0, exc_code=0, irq_pending=0.
- While rst is high, every combinational output is forced to 0.
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, EXC=5. Outputs are Moore-decoded from state, plus the inputs noted below.
- IF:
  - Drives mem_req=1 and mem_ifetch=1.
  - On mem_ack: ir_wr=1, pc_wr=1, npc_sel=0, then go to ID.
  - Timeout expiry: exc_code=6 (IBE), epc_sel=0, go to EXC.
- ID: no strobes.
  - cls=7: exc_code=10 (RI), epc_sel=1, go to EXC.
  - Otherwise go to EX.
- EX, by class:
  - ALU: if alu_ovf, exc_code=12 (Ov), epc_sel=1, go to EXC; gpr_wr is suppressed. Otherwise go to WB.
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_wr=br_take, npc_sel=br_sel; this is an instruction boundary.
  - JAL: pc_wr=1, npc_sel=2, gpr_wr=1; boundary.
  - MTC0: cp0_we=1; boundary.
  - ERET: pc_wr=1, npc_sel=5, exl_clr=1; boundary.
- MEM:
  - Drives mem_req=1, and mem_we=1 for STORE.
  - req stays high until ack.
  - On ack: LOAD goes to WB; STORE is a boundary.
  - Timeout expiry: exc_code=7 (DBE), epc_sel=1, go to EXC.
- WB: gpr_wr=1; boundary.
- Boundary rule:
  - Take an interrupt iff |(irq & irq_mask) && ie && !exl, sampled that cycle.
  - If taken: irq_pending <= irq & irq_mask, exc_code <= 0, epc_sel=0, go to EXC.
  - Otherwise go to IF.
  - ERET's boundary uses the old exl=1, so no interrupt is taken there; a pending interrupt is taken at the next boundary.
- EXC: single cycle. pc_wr=1, npc_sel=4, epc_wr=1, exl_set=1, cause_wr=1, then go to IF. exc_code and epc_sel hold their EXC-entry values.
- Priority: a synchronous exception in a state beats an interrupt. An interrupt is considered only at a boundary, never mid-instruction.
- Timeout counter:
  - Cleared on entering IF or MEM and on ack.
  - Increments each cycle with mem_req=1 and mem_ack=0.
  - Expiry occurs when count==MEM_TIMEOUT-1 and no ack. mem_req drops the next cycle.
  - If ack and expiry coincide, the ack wins.
- Latency with zero-wait memory (single-cycle ack): ALU 4 cycles, LOAD 5, STORE 4, BRANCH/JAL/MTC0/ERET 3, plus 1 for EXC.
- Reset mid-transfer abandons the request immediately; no strobes are issued for the aborted cycle.

Test Plan:
- ALU, ack in the same cycle as req, no irq → state sequence 0,1,2,4,0. gpr_wr is high only in WB. pc_wr is high only in IF with npc_sel=0.
- LOAD with mem_ack delayed 3 cycles in MEM → mem_req stays high 4 cycles; WB follows; gpr_wr pulses once.
- MEM_TIMEOUT=4, STORE, ack never arrives → mem_req high exactly 4 cycles, then EXC with exc_code=7, epc_sel=1, exl_set=1, npc_sel=4.
- irq=6'b000100, irq_mask=6'b000100, ie=1, exl=0 during ALU WB → next state is EXC with exc_code=0 and irq_pending=6'b000100. Repeat with the mask bit cleared → no EXC.
- ADDI overflow (alu_ovf=1 in EX) while an irq is also pending → EXC with exc_code=12, gpr_wr never asserted, epc_sel=1.
- cls=7 → EXC with code 10. ERET with exl=1 and an irq pending → PC takes EPC; the interrupt is taken at the boundary of the following instruction. Asserting rst mid-MEM → all outputs 0, and state=IF after release.
